// File: rtl/mem_arbiter_rr_pkg.sv
// Shared definitions for the N-channel RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Width of a channel index; at least one bit so N=1 corner builds still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_rr_picker.sv
// One-hot request picker: round-robin from ptr+1 with wrap, or lowest index in fixed mode.
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when no request is present.
import mem_arbiter_rr_pkg::*;

module rr_picker #(
  parameter int N          = 2,
  parameter int FIXED_PRIO = 0,
  parameter int IW         = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;

  // Search the request vector in priority order and report the first hit
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    if (FIXED_PRIO != 0) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i]) begin
          found = 1'b1;
          idx   = IW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(int'(ptr) + k) % N]) begin
          found = 1'b1;
          idx   = IW'((int'(ptr) + k) % N);
        end
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Arbitrates N core memory ports onto one single-port synchronous RAM (1-cycle read latency).
// Latency: write done 2 cycles after request sampling, read done 3 cycles after.
// Backpressure: losers simply stay pending (level requests); requests are ignored while a transfer is in flight.
import mem_arbiter_rr_pkg::*;

module mem_arbiter_rr #(
  parameter int N          = 2,
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    rden,
  input  logic [N-1:0]    wren,
  input  logic [N-1:0]    lock,
  input  logic [N*AW-1:0] Address,
  input  logic [N*DW-1:0] Din,
  input  logic [DW-1:0]   RAMq,
  output logic [N-1:0]    acq,
  output logic [N-1:0]    done,
  output logic [N*DW-1:0] Dq,
  output logic [AW-1:0]   RAMAddress,
  output logic [DW-1:0]   RAMDin,
  output logic            RAMwren
);

  localparam int IW = idx_w(N);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   g_l;
  logic            op_l;
  logic [AW-1:0]   addr_l;
  logic [DW-1:0]   din_l;
  logic [IW-1:0]   lock_owner;
  logic            lock_vld;
  logic [N-1:0]    done_q;
  logic [N*DW-1:0] dq_q;

  logic [N-1:0]    req;
  logic [N-1:0]    pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            lock_hit;
  logic [IW-1:0]   g_sel;
  logic            start;
  logic            complete;

  assign req      = rden | wren;
  // A held lock only wins if its owner is actually asking again.
  assign lock_hit = lock_vld && req[lock_owner];
  assign g_sel    = lock_hit ? lock_owner : pick_idx;
  assign start    = (state == IDLE) && (|pick_gnt);
  assign complete = ((state == ACCESS) && (op_l == OP_WR)) || (state == RDWAIT);

  rr_picker #(.N(N), .FIXED_PRIO(FIXED_PRIO), .IW(IW)) u_picker (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: writes finish out of ACCESS, reads take one extra cycle for RAM latency
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  state_nxt = (op_l == OP_WR) ? IDLE : RDWAIT;
      RDWAIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, lock tracking, completion pulse and per-channel read data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= IW'(N - 1);
      g_l        <= '0;
      op_l       <= OP_RD;
      addr_l     <= '0;
      din_l      <= '0;
      lock_owner <= '0;
      lock_vld   <= 1'b0;
      done_q     <= '0;
      dq_q       <= '0;
    end else begin
      done_q <= '0;
      if (start) begin
        g_l      <= g_sel;
        op_l     <= wren[g_sel] ? OP_WR : OP_RD;
        addr_l   <= Address[int'(g_sel)*AW +: AW];
        din_l    <= Din[int'(g_sel)*DW +: DW];
        ptr      <= g_sel;
        lock_vld <= lock_hit;
      end
      if (complete) begin
        done_q[g_l] <= 1'b1;
        lock_vld    <= lock[g_l];
        lock_owner  <= g_l;
        if (state == RDWAIT) dq_q[int'(g_l)*DW +: DW] <= RAMq;
      end
    end
  end

  // Outputs decode from registers only; RAM address/data hold their last value when idle
  always_comb begin
    acq = '0;
    if (state != IDLE) acq[g_l] = 1'b1;
    RAMwren    = (state == ACCESS) && (op_l == OP_WR);
    RAMAddress = addr_l;
    RAMDin     = din_l;
    done       = done_q;
    Dq         = dq_q;
  end

endmodule
